// File: rtl/cbus_rr_arbiter_pkg.sv
// cbus_rr_arbiter_pkg
//   Shared CBus types for the I/D-side arbiter: request/response structs,
//   burst length / transfer size encodings, arbiter FSM state and the
//   default master count. A small helper sizes grant indices safely for
//   a single-master build.
package cbus_rr_arbiter_pkg;

   localparam int CBUS_NUM_MASTERS = 2;

   // Burst length encoded as (beats - 1)
   typedef enum logic [3:0] {
      MLEN1  = 4'd0,
      MLEN2  = 4'd1,
      MLEN4  = 4'd3,
      MLEN8  = 4'd7,
      MLEN16 = 4'd15
   } cbus_len_t;

   typedef enum logic [2:0] {
      MSIZE1 = 3'd0,
      MSIZE2 = 3'd1,
      MSIZE4 = 3'd2
   } cbus_size_t;

   typedef struct packed {
      logic        valid;
      logic        is_write;
      cbus_size_t  size;
      logic [31:0] addr;
      logic [3:0]  strobe;
      logic [31:0] data;
      cbus_len_t   len;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [31:0] data;
   } cbus_resp_t;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_t;

   // Index width that never collapses to zero bits
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cbus_rr_arbiter_if.sv
// cbus_rr_arbiter_if
//   Bundles the arbiter's bus-side signals.
//     ireqs     : per-master CBus requests
//     iresps    : per-master CBus responses
//     oreq      : request toward memory
//     oresp     : response from memory
//     busy      : a transaction is locked
//     grant_idx : locked master index (meaningful only while busy)
//   Modports:
//     master : arbiter view (it masters the external CBus port)
//     slave  : environment view (CPU masters + memory)
interface cbus_rr_arbiter_if
   import cbus_rr_arbiter_pkg::*;
#(
   parameter int NUM_INPUTS = CBUS_NUM_MASTERS,
   parameter int IDX_W      = idx_width(NUM_INPUTS)
) ();

   cbus_req_t  [NUM_INPUTS-1:0] ireqs;
   cbus_resp_t [NUM_INPUTS-1:0] iresps;
   cbus_req_t                   oreq;
   cbus_resp_t                  oresp;
   logic                        busy;
   logic       [IDX_W-1:0]      grant_idx;

   modport master (
      input  ireqs, oresp,
      output iresps, oreq, busy, grant_idx
   );

   modport slave (
      output ireqs, oresp,
      input  iresps, oreq, busy, grant_idx
   );

endinterface

// File: rtl/cbus_rr_arbiter_rr_picker.sv
// rr_picker
//   Combinational rotate-and-priority-encode. Scans the valid vector
//   starting at ptr, wrapping modulo NUM_INPUTS; the first set bit wins.
//     valid  : request valid per master
//     ptr    : scan start index (must be < NUM_INPUTS)
//     winner : selected index (0 when none valid)
//     any    : at least one valid request
module rr_picker
   import cbus_rr_arbiter_pkg::*;
#(
   parameter int NUM_INPUTS = CBUS_NUM_MASTERS,
   parameter int IDX_W      = idx_width(NUM_INPUTS)
) (
   input  logic [NUM_INPUTS-1:0] valid,
   input  logic [IDX_W-1:0]      ptr,
   output logic [IDX_W-1:0]      winner,
   output logic                  any
);

   logic [IDX_W:0] pos;

   always_comb begin
      winner = '0;
      any    = 1'b0;
      pos    = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         // one extra bit keeps ptr+i from overflowing before the wrap
         pos = {1'b0, ptr} + (IDX_W+1)'(i);
         if (pos >= (IDX_W+1)'(NUM_INPUTS))
            pos = pos - (IDX_W+1)'(NUM_INPUTS);
         if (!any && valid[pos[IDX_W-1:0]]) begin
            any    = 1'b1;
            winner = pos[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/cbus_rr_arbiter.sv
// cbus_rr_arbiter
//   Locks one CBus master onto the external port from grant until the
//   final acknowledged beat, then returns to IDLE (one bubble cycle
//   between transactions). While BUSY, oreq/iresps are pure
//   combinational pass-through of the locked master.
//   Ports:
//     clk   : system clock
//     reset : asynchronous active-high reset
//     bus   : cbus_rr_arbiter_if.master (ireqs, iresps, oreq, oresp,
//             busy, grant_idx)
//   Build option:
//     CBUS_ARB_RR_EN : defined -> round-robin scan starting after the
//                      last served master; undefined -> fixed priority,
//                      lowest index wins.
module cbus_rr_arbiter
   import cbus_rr_arbiter_pkg::*;
#(
   parameter int NUM_INPUTS = CBUS_NUM_MASTERS,
   parameter int IDX_W      = idx_width(NUM_INPUTS)
) (
   input logic                clk,
   input logic                reset,
   cbus_rr_arbiter_if.master  bus
);

   arb_state_t             state_q, state_d;
   logic [IDX_W-1:0]       sel_q, sel_d;
   logic [IDX_W-1:0]       scan_ptr;
   logic [IDX_W-1:0]       winner;
   logic                   any;
   logic [NUM_INPUTS-1:0]  valid_vec;
   logic                   done;

   for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_valid
      assign valid_vec[g] = bus.ireqs[g].valid;
   end

   assign done = bus.oresp.ready && bus.oresp.last;

`ifdef CBUS_ARB_RR_EN
   logic [IDX_W-1:0] ptr_q, ptr_d;

   // next scan starts just past the master that finished
   always_comb begin
      ptr_d = ptr_q;
      if (state_q == ARB_BUSY && done)
         ptr_d = (sel_q == IDX_W'(NUM_INPUTS-1)) ? '0 : sel_q + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end

   assign scan_ptr = ptr_q;
`else
   assign scan_ptr = '0;
`endif

   rr_picker #(
      .NUM_INPUTS (NUM_INPUTS),
      .IDX_W      (IDX_W)
   ) u_picker (
      .valid  (valid_vec),
      .ptr    (scan_ptr),
      .winner (winner),
      .any    (any)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ARB_IDLE;
         sel_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      bus.oreq   = '0;
      bus.iresps = '0;
      case (state_q)
         ARB_IDLE: begin
            if (any) begin
               sel_d   = winner;
               state_d = ARB_BUSY;
            end
         end
         ARB_BUSY: begin
            // lock holds until last even if the master drops valid
            bus.oreq          = bus.ireqs[sel_q];
            bus.iresps[sel_q] = bus.oresp;
            if (done)
               state_d = ARB_IDLE;
         end
      endcase
   end

   assign bus.busy      = (state_q == ARB_BUSY);
   assign bus.grant_idx = sel_q;

`ifndef SYNTHESIS
   // locked master must keep valid up until its final beat
   a_lock_valid: assert property (@(posedge clk) disable iff (reset)
      (state_q == ARB_BUSY) |-> bus.ireqs[sel_q].valid);
`endif

endmodule

// File: doc/cbus_rr_arbiter.md
# cbus_rr_arbiter

Arbitrates between the cached/uncached instruction-side and data-side CBus masters and drives the single external CBus port (`oreq`/`oresp`) out of the CPU top. It holds one master's transaction from grant until the final beat is acknowledged, then returns to idle. It selects the next master by round-robin or by fixed priority. It sits directly downstream of the I/D request muxes in the core top and replaces the stock CBus mux.

## Interface
- `NUM_INPUTS`, default 2: number of CBus masters. Index 0 is the I-side and index 1 is the D-side.
- `IDX_W`, default `$clog2(NUM_INPUTS)`: width of the grant index.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `ireqs`  in  `cbus_req_t [NUM_INPUTS]`  master requests.
- `iresps`  out  `cbus_resp_t [NUM_INPUTS]`  per-master responses.
- `oreq`  out  `cbus_req_t`  request to memory.
- `oresp`  in  `cbus_resp_t`  response from memory.
- `busy`  out  1  high while a transaction is locked.
- `grant_idx`  out  `IDX_W`  index of the locked master. This output is valid only when `busy` is high.

## Operation
- The FSM has two states, IDLE and BUSY.
- **IDLE**
  - `oreq` = all-zero. All `iresps` = all-zero.
  - If any `ireqs[i].valid` is high, the arbiter selects a winner (see priority below).
  - It registers the winner into `sel_q`, and the state becomes BUSY on the next edge.
- **BUSY**
  - `oreq` = `ireqs[sel_q]`, passed through combinationally so per-beat write data and strobe pass untouched.
  - `iresps[sel_q]` = `oresp`. All other `iresps` = zero.
  - On `oresp.ready && oresp.last`:
    - the state becomes IDLE next cycle;
    - the round-robin pointer `ptr_q` is set to `sel_q+1`, wrapping to 0 at `NUM_INPUTS`.
- **Priority:** the arbiter scans indices starting at `ptr_q` and wrapping modulo `NUM_INPUTS`. The first valid index wins.
- **Lock:** while BUSY, requests from other masters are ignored regardless of priority.
- **Protocol violation:** if the granted master drops `valid` while BUSY, the lock is still held until `last`. In simulation this is flagged with an assertion.
- **Reset (including mid-transaction):**
  - state = IDLE, `sel_q` = 0, `ptr_q` = 0;
  - `oreq`, `iresps`, `busy` and `grant_idx` all go to zero immediately.
  - An in-flight memory burst is abandoned. The memory side is reset by the same signal.

## Timing
- Grant latency is 1 cycle. When `valid` is first seen in IDLE, `oreq.valid` is high in the following cycle.
- There is exactly one IDLE bubble cycle between consecutive transactions, even if another master is waiting.
- Single-beat transaction: `ready&last` in cycle N means IDLE in N+1, and the next grant's `oreq.valid` in N+2.
- `oresp` to `iresps` has zero-cycle latency. `oresp.ready` is never asserted to a non-granted master.
- `busy` and `grant_idx` are registered and change only at clock edges.

## Configuration
- `CBUS_ARB_RR_EN`
  - Defined: round-robin priority as described above.
  - Undefined: fixed priority, where the lowest index wins. `ptr_q` is removed and the scan always starts at 0.

## Structure
- The shared package (alongside `cbus_req_t`/`cbus_resp_t`) holds:
  - `arb_state_t` enum {`ARB_IDLE`, `ARB_BUSY`};
  - the `CBUS_NUM_MASTERS` = 2 constant.
- One sub-module, `rr_picker`, is natural: it is a combinational rotate-and-priority-encode. Its inputs are the valid vector and `ptr`. Its outputs are `winner` and `any`.
- `cbus_rr_arbiter` instantiates `rr_picker` once.

## Test plan
- **Single request:** I-side valid, `len`=MLEN16, with memory giving ready on every beat.
  - Grant at cycle 1, `grant_idx`=0.
  - 16 beats go through `iresps[0]`.
  - IDLE in the cycle after beat 16's `last`.
- **Simultaneous requests after reset:** I and D both valid.
  - I is granted first (`ptr`=0).
  - Then after the bubble, D is granted. With `CBUS_ARB_RR_EN` defined, `ptr` becomes 0 after D finishes.
- **Repeated I requests with D waiting:**
  - With round-robin: D is granted immediately after the first I transaction.
  - Without `CBUS_ARB_RR_EN`: I is granted again.
- **Lock check:** D is granted. I raises `valid` mid-burst.
  - `oreq` tracks `ireqs[1]` until `last`.
  - `iresps[0].ready` stays 0 throughout.
- **Uncached D write, `len`=MLEN1, strobe 4'b1111, data 32'hDEADBEEF:**
  - `oreq` is identical to `ireqs[1]` during BUSY.
  - Transaction completes in 1 beat.
- **Reset asserted on beat 5 of a 16-beat burst:**
  - `oreq.valid` and `busy` go to 0 asynchronously.
  - After release, a new D request is granted with `ptr`=0.
